// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the TX feeder FSM state encoding.
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port plus UART_TX parallel handshake, grouped for the feeder.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  WR_EN;
    logic                  FULL;
    logic                  EMPTY;
    logic [CW-1:0]         COUNT;
    logic                  OVERFLOW;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_DATA_VALID;
    logic                  TX_BUSY;
    logic                  TX_ERR;

    // Host / transmitter side.
    modport master (
        output WR_DATA, WR_EN, TX_BUSY,
        input  FULL, EMPTY, COUNT, OVERFLOW, TX_P_DATA, TX_DATA_VALID, TX_ERR
    );

    // Feeder side.
    modport slave (
        input  WR_DATA, WR_EN, TX_BUSY,
        output FULL, EMPTY, COUNT, OVERFLOW, TX_P_DATA, TX_DATA_VALID, TX_ERR
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO; occupancy counter drives registered full/empty and the overflow pulse.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             wr_en,
    input  logic                             pop,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(FIFO_DEPTH):0]      count,
    output logic                             overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_acc;
    logic                  pop_acc;

    // Writes look only at the registered full flag, so a same-cycle pop never frees a slot.
    always_comb begin
        wr_acc     = wr_en & ~full_q;
        pop_acc    = pop & ~empty_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d    = count_q + CW'(wr_acc) - CW'(pop_acc);
        full_d     = (count_d == CW'(FIFO_DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = wr_en & full_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains the byte FIFO into UART_TX: one valid pulse per byte, paced on the transmitter's Busy.
//
// state     | meaning
// IDLE      | waiting for a byte; pops the FIFO head into TX_P_DATA
// ISSUE     | TX_DATA_VALID high for this single cycle
// WAIT_BUSY | waiting for Busy to rise; gives up after BUSY_TIMEOUT cycles
// WAIT_DONE | frame on the line; waiting for Busy to fall
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_feeder_if.slave  bus
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    feeder_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [TW-1:0]         tmo_inc;
    logic                  pop;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_data  (bus.WR_DATA),
        .wr_en    (bus.WR_EN),
        .pop      (pop),
        .rd_data  (fifo_rd_data),
        .full     (bus.FULL),
        .empty    (fifo_empty),
        .count    (bus.COUNT),
        .overflow (bus.OVERFLOW)
    );

    always_comb begin
        state_d  = state_q;
        p_data_d = p_data_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        tmo_inc  = tmo_q + TW'(1);
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    p_data_d = fifo_rd_data;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.TX_BUSY) begin
                    state_d = WAIT_DONE;
                end else begin
                    tmo_d = tmo_inc;
                    // Busy never came: the byte is abandoned and the error latches.
                    if (tmo_inc == TW'(BUSY_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.TX_BUSY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            p_data_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_data_q <= p_data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.EMPTY         = fifo_empty;
    assign bus.TX_P_DATA     = p_data_q;
    assign bus.TX_DATA_VALID = valid_q;
    assign bus.TX_ERR        = err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple UART_TX Busy responder.
module tb_uart_tx_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) bus ();

    uart_tx_feeder #(
        .DATA_WIDTH   (8),
        .FIFO_DEPTH   (8),
        .BUSY_TIMEOUT (4)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Busy responder: rises one cycle after a valid pulse, stays high for 10 cycles.
    logic [7:0] rx_q [$];
    bit         busy_en   = 1'b1;
    bit         hold_busy = 1'b0;
    bit         pend      = 1'b0;
    int         busy_left = 0;
    int         ovf_cnt   = 0;
    int         max_count = 0;
    int         gap_viol  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend        = 1'b0;
            busy_left   = 0;
            bus.TX_BUSY = 1'b0;
        end else begin
            if (bus.OVERFLOW) ovf_cnt++;
            if (int'(bus.COUNT) > max_count) max_count = int'(bus.COUNT);
            if (bus.TX_DATA_VALID) begin
                rx_q.push_back(bus.TX_P_DATA);
                if (bus.TX_BUSY || pend) gap_viol++;
                pend = busy_en;
            end else if (pend) begin
                pend        = 1'b0;
                bus.TX_BUSY = 1'b1;
                busy_left   = 9;
            end else if (bus.TX_BUSY && (busy_left > 0 || hold_busy)) begin
                if (busy_left > 0) busy_left--;
            end else begin
                bus.TX_BUSY = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.WR_DATA = d;
        bus.WR_EN   = 1'b1;
        tick();
        bus.WR_EN   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_val("wait_rx", rx_q.size(), n);
    endtask

    initial begin
        int base;
        bus.WR_EN   = 1'b0;
        bus.WR_DATA = 8'h00;
        rst_n       = 1'b0;
        repeat (3) tick();

        check_val("rst_empty", bus.EMPTY, 1);
        check_val("rst_full", bus.FULL, 0);
        check_val("rst_count", bus.COUNT, 0);
        check_val("rst_ovf", bus.OVERFLOW, 0);
        check_val("rst_valid", bus.TX_DATA_VALID, 0);
        check_val("rst_err", bus.TX_ERR, 0);
        check_val("rst_pdata", bus.TX_P_DATA, 0);
        rst_n = 1'b1;
        tick();

        // Single byte: valid two cycles after the write cycle.
        write_byte(8'hA5);
        check_val("a5_count", bus.COUNT, 1);
        check_val("a5_empty", bus.EMPTY, 0);
        check_val("a5_valid_early", bus.TX_DATA_VALID, 0);
        tick();
        check_val("a5_valid", bus.TX_DATA_VALID, 1);
        check_val("a5_pdata", bus.TX_P_DATA, 8'hA5);
        tick();
        check_val("a5_valid_1cyc", bus.TX_DATA_VALID, 0);
        repeat (20) tick();
        check_val("a5_rx_size", rx_q.size(), 1);
        check_val("a5_empty_after", bus.EMPTY, 1);

        // Park the FSM in WAIT_DONE, fill the FIFO, then overflow it.
        write_byte(8'h5A);
        hold_busy = 1'b1;
        wait_rx(2, 20);
        repeat (3) tick();
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        check_val("burst_count", bus.COUNT, 8);
        check_val("burst_full", bus.FULL, 1);
        write_byte(8'hFF);
        check_val("ovf_pulse", bus.OVERFLOW, 1);
        check_val("ovf_count", bus.COUNT, 8);
        tick();
        check_val("ovf_clear", bus.OVERFLOW, 0);
        hold_busy = 1'b0;
        wait_rx(10, 250);
        for (int i = 0; i < 8; i++) check_val("burst_order", rx_q[2 + i], 8'(i + 1));
        repeat (15) tick();
        check_val("burst_empty", bus.EMPTY, 1);

        // No Busy response: error after 4 wait cycles, next byte still issued.
        busy_en = 1'b0;
        write_byte(8'h3C);
        write_byte(8'h3D);
        check_val("tmo_valid", bus.TX_DATA_VALID, 1);
        check_val("tmo_pdata", bus.TX_P_DATA, 8'h3C);
        repeat (4) tick();
        check_val("tmo_err_early", bus.TX_ERR, 0);
        tick();
        check_val("tmo_err_set", bus.TX_ERR, 1);
        check_val("tmo_pdata_hold", bus.TX_P_DATA, 8'h3C);
        tick();
        check_val("tmo_next_valid", bus.TX_DATA_VALID, 1);
        check_val("tmo_next_pdata", bus.TX_P_DATA, 8'h3D);
        repeat (10) tick();
        check_val("tmo_err_sticky", bus.TX_ERR, 1);
        busy_en = 1'b1;

        // Interleaved writes and drains; pointers wrap past 16 and 24.
        base = rx_q.size();
        for (int g = 0; g < 3; g++) begin
            for (int j = 0; j < 4; j++) write_byte(8'hC0 + 8'(4 * g + j));
            if (g < 2) wait_rx(base + 4 * g + 2, 100);
        end
        wait_rx(base + 12, 250);
        for (int i = 0; i < 12; i++) check_val("wrap_order", rx_q[base + i], 8'hC0 + 8'(i));
        check_val("wrap_max_count_le8", max_count <= 8, 1);
        repeat (15) tick();

        // Reset while a frame is in flight with 3 bytes queued.
        hold_busy = 1'b1;
        write_byte(8'h11);
        wait_rx(base + 13, 20);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        repeat (3) tick();
        check_val("pre_rst_count", bus.COUNT, 3);
        rst_n = 1'b0;
        tick();
        check_val("mrst_empty", bus.EMPTY, 1);
        check_val("mrst_count", bus.COUNT, 0);
        check_val("mrst_full", bus.FULL, 0);
        check_val("mrst_ovf", bus.OVERFLOW, 0);
        check_val("mrst_err", bus.TX_ERR, 0);
        check_val("mrst_valid", bus.TX_DATA_VALID, 0);
        check_val("mrst_pdata", bus.TX_P_DATA, 0);
        hold_busy = 1'b0;
        rst_n     = 1'b1;
        repeat (40) tick();
        check_val("mrst_no_more_valid", rx_q.size(), base + 13);
        check_val("ovf_total", ovf_cnt, 1);
        check_val("busy_gap", gap_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
